// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

  localparam int WIDTH = 32;

  // Canonical RISC-V no-op (addi x0, x0, 0).
  localparam logic [WIDTH-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: instruction memory read port, branch redirect and
// the decode handshake.
//
// Handshake: id_valid/id_instr/id_pc are driven by fetch and describe
// the queue head; an entry transfers on a rising edge where id_valid
// and id_ready are both high. id_valid never waits on id_ready, and the
// head payload is stable while id_valid is high and not yet accepted.
// A redirect in the same cycle cancels the transfer.
interface fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             id_valid;
  logic             id_ready;
  logic [WIDTH-1:0] id_instr;
  logic [WIDTH-1:0] id_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry fetch queue. The head is held in output registers so that
// decode sees registered values; the head keeps its last value when the
// queue is empty or flushed.
module fetch_queue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_instr,
  input  logic             pop,
  input  logic             flush,
  output logic [1:0]       count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_pc,
  output logic [WIDTH-1:0] head_instr
);

  logic [WIDTH-1:0] pc_mem    [2];
  logic [WIDTH-1:0] instr_mem [2];
  logic             rptr;
  logic             wptr;
  logic [1:0]       count_q;
  logic             pop_eff;
  logic             push_eff;
  logic             rptr_next;
  logic [1:0]       count_next;
  logic [WIDTH-1:0] head_pc_next;
  logic [WIDTH-1:0] head_instr_next;

  // Effective push/pop and the entry that will sit at the head next cycle;
  // it is the word being written now when the queue would otherwise drain.
  always_comb begin
    pop_eff    = pop & (count_q != 2'd0) & ~flush;
    push_eff   = push & ~flush;
    rptr_next  = rptr ^ pop_eff;
    count_next = count_q + {1'b0, push_eff} - {1'b0, pop_eff};
    if (push_eff && (rptr_next == wptr)) begin
      head_pc_next    = push_pc;
      head_instr_next = push_instr;
    end else begin
      head_pc_next    = pc_mem[rptr_next];
      head_instr_next = instr_mem[rptr_next];
    end
  end

  // Storage slots; contents are only meaningful under count.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      pc_mem[wptr]    <= push_pc;
      instr_mem[wptr] <= push_instr;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr       <= 1'b0;
      wptr       <= 1'b0;
      count_q    <= 2'd0;
      head_valid <= 1'b0;
      head_pc    <= '0;
      head_instr <= '0;
    end else if (flush) begin
      rptr       <= 1'b0;
      wptr       <= 1'b0;
      count_q    <= 2'd0;
      head_valid <= 1'b0;
    end else begin
      rptr       <= rptr_next;
      wptr       <= wptr ^ push_eff;
      count_q    <= count_next;
      head_valid <= (count_next != 2'd0);
      if (count_next != 2'd0) begin
        head_pc    <= head_pc_next;
        head_instr <= head_instr_next;
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory
// combinationally, queues {pc, instr} pairs for decode, and handles
// start-up, branch redirects and running off the end of memory.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = cpu_pkg::WIDTH,
  parameter int               DEPTH    = 512,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  fetch_sequencer_if.master bus,
  output logic              halted,
  output fetch_state_t      state_dbg
);

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus1;
  logic             redirect;
  logic             pop;
  logic             fetch;
  logic             flush;
  logic             q_valid;
  logic [1:0]       q_count;
  logic [WIDTH-1:0] q_pc;
  logic [WIDTH-1:0] q_instr;

  assign pc_plus1 = pc + WIDTH'(1);
  assign pop      = q_valid & bus.id_ready;
  assign redirect = bus.redirect_valid & (state != IDLE);

  // Next state, next PC and fetch enable; a redirect overrides everything.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    fetch      = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush      = 1'b1;
      pc_next    = bus.redirect_pc;
      state_next = (bus.redirect_pc < DEPTH_W) ? RUN : HALT;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_next = RUN;
        end
        RUN: begin
          if (pc >= DEPTH_W) begin
            // Only reachable with RESET_PC outside memory.
            state_next = HALT;
          end else if ((q_count < 2'd2) || pop) begin
            fetch   = 1'b1;
            pc_next = pc_plus1;
            if (pc_plus1 >= DEPTH_W) state_next = HALT;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  fetch_queue #(
    .WIDTH(WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fetch),
    .push_pc    (pc),
    .push_instr (bus.imem_rdata),
    .pop        (pop),
    .flush      (flush),
    .count      (q_count),
    .head_valid (q_valid),
    .head_pc    (q_pc),
    .head_instr (q_instr)
  );

  assign bus.imem_addr = pc;
  assign bus.id_valid  = q_valid;
  assign bus.id_pc     = q_pc;
  assign bus.id_instr  = q_instr;
  assign halted        = (state == HALT);
  assign state_dbg     = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer. A small memory sits on the imem port; the
// scoreboard expects decode to see the program-order stream starting at
// the last start/redirect target and ending at the top of memory.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  localparam int DEPTH = 96;  // large enough for the pc-87 redirect
  localparam logic [WIDTH-1:0] RESET_PC = '0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         halted;
  fetch_state_t state_dbg;

  fetch_sequencer_if #(.WIDTH(WIDTH)) bus ();

  fetch_sequencer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- instruction memory ----------------
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    if (bus.imem_addr < DEPTH) bus.imem_rdata = mem[bus.imem_addr[6:0]];
    else                       bus.imem_rdata = 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard ----------------
  fetch_entry_t exp_q[$];
  fetch_entry_t sb_e;
  bit           model_idle = 1'b1;
  int           n_deliv = 0;

  function automatic void load_stream(input logic [WIDTH-1:0] from_pc);
    exp_q.delete();
    for (longint p = from_pc; p < DEPTH; p++) begin
      exp_q.push_back('{pc: WIDTH'(p), instr: mem[p]});
    end
  endfunction

  // Inputs change just after posedge; sampling mid-cycle sees exactly
  // what the next edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_idle = 1'b1;
    end else if (model_idle) begin
      if (start) begin
        model_idle = 1'b0;
        load_stream(RESET_PC);
      end
    end else if (bus.redirect_valid) begin
      load_stream(bus.redirect_pc);
    end else if (bus.id_valid && bus.id_ready) begin
      n_checks++;
      n_deliv++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got pc=%0d instr=%h, expected nothing", bus.id_pc, bus.id_instr);
      end else begin
        sb_e = exp_q.pop_front();
        if (bus.id_pc !== sb_e.pc || bus.id_instr !== sb_e.instr) begin
          n_fail++;
          $display("FAIL sb_order: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                   bus.id_pc, bus.id_instr, sb_e.pc, sb_e.instr);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %0b want 0", bus.id_valid); end
    n_checks++; if (bus.id_pc !== '0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); end
    n_checks++; if (bus.id_instr !== '0) begin n_fail++; $display("FAIL reset_id_instr: got %h want 0", bus.id_instr); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_checks++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_imem_addr: got %0d want %0d", bus.imem_addr, RESET_PC); end
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    bus.id_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL idle_no_fetch: got valid=%0b addr=%0d want 0/%0d", bus.id_valid, bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_start_stream();
    do_reset();
    do_start();
    n_checks++; if (state_dbg !== RUN || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL start_edge: got state=%0d valid=%0b want RUN/0", state_dbg, bus.id_valid);
    end
    bus.id_ready = 1'b1;
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd0 || bus.id_instr !== 32'h0000_0113) begin
      n_fail++; $display("FAIL stream_0: got v=%0b pc=%0d instr=%h want 1/0/00000113", bus.id_valid, bus.id_pc, bus.id_instr);
    end
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd1 || bus.id_instr !== 32'h0000_0113) begin
      n_fail++; $display("FAIL stream_1: got v=%0b pc=%0d instr=%h want 1/1/00000113", bus.id_valid, bus.id_pc, bus.id_instr);
    end
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd2 || bus.id_instr !== 32'h0040_0093) begin
      n_fail++; $display("FAIL stream_2: got v=%0b pc=%0d instr=%h want 1/2/00400093", bus.id_valid, bus.id_pc, bus.id_instr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    do_start();
    bus.id_ready = 1'b0;
    repeat (5) tick();
    n_checks++; if (bus.imem_addr !== 32'd2) begin n_fail++; $display("FAIL bp_pc_freeze: got %0d want 2", bus.imem_addr); end
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd0) begin
      n_fail++; $display("FAIL bp_head: got v=%0b pc=%0d want 1/0", bus.id_valid, bus.id_pc);
    end
    bus.id_ready = 1'b1;
    tick();
    n_checks++; if (bus.id_pc !== 32'd1 || bus.imem_addr !== 32'd3) begin
      n_fail++; $display("FAIL bp_release: got pc=%0d addr=%0d want 1/3", bus.id_pc, bus.imem_addr);
    end
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd2) begin
      n_fail++; $display("FAIL bp_resume: got v=%0b pc=%0d want 1/2", bus.id_valid, bus.id_pc);
    end
  endtask

  task automatic test_redirect();
    int waited;
    do_reset();
    do_start();
    bus.id_ready = 1'b1;
    waited = 0;
    while (!(bus.id_valid === 1'b1 && bus.id_pc === 32'd10) && waited < 40) begin
      tick();
      waited++;
    end
    n_checks++; if (waited >= 40) begin n_fail++; $display("FAIL redir_wait_pc10: got pc=%0d want 10 within 40 cycles", bus.id_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd87;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'd87) begin
      n_fail++; $display("FAIL redir_flush: got v=%0b addr=%0d want 0/87", bus.id_valid, bus.imem_addr);
    end
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd87 || bus.id_instr !== 32'h0020_2303) begin
      n_fail++; $display("FAIL redir_target: got v=%0b pc=%0d instr=%h want 1/87/00202303", bus.id_valid, bus.id_pc, bus.id_instr);
    end
    repeat (3) tick();
  endtask

  task automatic test_halt();
    int waited;
    do_reset();
    do_start();
    bus.id_ready = 1'b1;
    waited = 0;
    while (halted !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    n_checks++; if (waited >= 200) begin n_fail++; $display("FAIL halt_wait: got halted=%0b want 1 within 200 cycles", halted); end
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(DEPTH - 1) || bus.imem_addr !== 32'(DEPTH)) begin
      n_fail++; $display("FAIL halt_entry: got v=%0b pc=%0d addr=%0d want 1/%0d/%0d", bus.id_valid, bus.id_pc, bus.imem_addr, DEPTH - 1, DEPTH);
    end
    repeat (4) tick();
    n_checks++; if (bus.id_valid !== 1'b0 || halted !== 1'b1 || bus.imem_addr !== 32'(DEPTH)) begin
      n_fail++; $display("FAIL halt_drained: got v=%0b h=%0b addr=%0d want 0/1/%0d", bus.id_valid, halted, bus.imem_addr, DEPTH);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd200;
    tick();
    n_checks++; if (halted !== 1'b1 || bus.imem_addr !== 32'd200 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_redir_oob: got h=%0b addr=%0d v=%0b want 1/200/0", halted, bus.imem_addr, bus.id_valid);
    end
    bus.redirect_pc = 32'd3;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (halted !== 1'b0 || bus.imem_addr !== 32'd3 || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_exit: got h=%0b addr=%0d v=%0b want 0/3/0", halted, bus.imem_addr, bus.id_valid);
    end
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd3 || bus.id_instr !== mem[3]) begin
      n_fail++; $display("FAIL halt_resume: got v=%0b pc=%0d instr=%h want 1/3/%h", bus.id_valid, bus.id_pc, bus.id_instr, mem[3]);
    end
  endtask

  task automatic test_redirect_full_pop();
    do_reset();
    do_start();
    bus.id_ready = 1'b0;
    repeat (3) tick();
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd40;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'd40) begin
      n_fail++; $display("FAIL fullpop_flush: got v=%0b addr=%0d want 0/40", bus.id_valid, bus.imem_addr);
    end
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd40 || bus.id_instr !== mem[40]) begin
      n_fail++; $display("FAIL fullpop_target: got v=%0b pc=%0d want 1/40", bus.id_valid, bus.id_pc);
    end
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd41) begin
      n_fail++; $display("FAIL fullpop_next: got v=%0b pc=%0d want 1/41", bus.id_valid, bus.id_pc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start();
    bus.id_ready = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.id_valid !== 1'b0 || halted !== 1'b0 || bus.imem_addr !== RESET_PC || state_dbg !== IDLE) begin
      n_fail++; $display("FAIL async_reset: got v=%0b h=%0b addr=%0d st=%0d want 0/0/%0d/IDLE",
                         bus.id_valid, halted, bus.imem_addr, state_dbg, RESET_PC);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL async_stays_idle: got v=%0b addr=%0d want 0/%0d", bus.id_valid, bus.imem_addr, RESET_PC);
    end
    do_start();
    tick();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== RESET_PC) begin
      n_fail++; $display("FAIL async_restart: got v=%0b pc=%0d want 1/%0d", bus.id_valid, bus.id_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    int deliv_before;
    do_reset();
    do_start();
    deliv_before = n_deliv;
    for (int i = 0; i < 800; i++) begin
      bus.id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'($urandom_range(0, DEPTH + 8));
      end else begin
        bus.redirect_valid = 1'b0;
      end
      tick();
      // Outside IDLE the machine is halted exactly when the PC is off the end.
      n_checks++; if (halted !== (bus.imem_addr >= DEPTH)) begin
        n_fail++; $display("FAIL rand_halt_vs_pc: got halted=%0b addr=%0d", halted, bus.imem_addr);
      end
    end
    bus.redirect_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (n_deliv - deliv_before < 100) begin
      n_fail++; $display("FAIL rand_progress: got %0d deliveries want >= 100", n_deliv - deliv_before);
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP ^ $urandom;
    mem[0]  = 32'h0000_0113;
    mem[1]  = 32'h0000_0113;
    mem[2]  = 32'h0040_0093;
    mem[87] = 32'h0020_2303;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b0;

    test_reset();
    test_start_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_redirect_full_pop();
    test_async_reset();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
